// File: rtl/kernel_pr_hls_deadlock_report_ctrl_if.sv
// Bus between the deadlock report sequencer (master) and the detect units plus
// report consumer (slave). state_dbg mirrors the sequencer FSM for checkers.
interface kernel_pr_hls_deadlock_report_ctrl_if #(
  parameter int PROC_NUM  = 4,
  parameter int PROC_ID_W = 2
);
  logic [PROC_NUM-1:0]  dl_detect_vec;
  logic [PROC_NUM-1:0]  token_seen_vec;
  logic                 dl_detect_glb;
  logic [PROC_NUM-1:0]  origin_vec;
  logic                 token_clear;
  // Report handshake: a transfer happens on the rising clock edge where
  // dl_report_vld and dl_report_ack are both 1. While vld is 1, id and mask
  // are held stable; vld never drops without ack; ack while vld is 0 is ignored.
  logic                 dl_report_vld;
  logic                 dl_report_ack;
  logic [PROC_ID_W-1:0] dl_report_id;
  logic [PROC_NUM-1:0]  dl_report_mask;
  logic [7:0]           dl_report_cnt;
  logic [2:0]           state_dbg;

  modport master (
    input  dl_detect_vec, token_seen_vec, dl_report_ack,
    output dl_detect_glb, origin_vec, token_clear, dl_report_vld,
           dl_report_id, dl_report_mask, dl_report_cnt, state_dbg
  );

  modport slave (
    output dl_detect_vec, token_seen_vec, dl_report_ack,
    input  dl_detect_glb, origin_vec, token_clear, dl_report_vld,
           dl_report_id, dl_report_mask, dl_report_cnt, state_dbg
  );
endinterface

// File: rtl/kernel_pr_hls_deadlock_report_ctrl.sv
// Deadlock report sequencer: debounce a detect, launch a token, trace it home,
// report the visited mask. Optional TRACE abort via DEADLOCK_TIMEOUT_EN.
module kernel_pr_hls_deadlock_report_ctrl #(
  parameter int PROC_NUM  = 4,
  parameter int PROC_ID_W = 2,
  parameter int DEBOUNCE  = 4,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic clock,
  input  logic reset,
  kernel_pr_hls_deadlock_report_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_LAUNCH = 3'd2,
    S_TRACE  = 3'd3,
    S_REPORT = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 1);

  if (DEBOUNCE < 1 || DEBOUNCE > 255 || TIMEOUT < 2 || CNT_W < 1 ||
      (1 << PROC_ID_W) < PROC_NUM) begin : g_cfg_err
    $error("kernel_pr_hls_deadlock_report_ctrl: invalid parameter set");
  end

  state_t               state;
  logic [PROC_ID_W-1:0] org_idx;
  logic [PROC_ID_W-1:0] low_idx;
  logic [7:0]           deb_cnt;
  logic [PROC_NUM-1:0]  mask;
  logic [PROC_NUM-1:0]  origin_q;
  logic                 glb_q;
  logic                 vld_q;
  logic [7:0]           rpt_cnt;
  logic                 zero_seen;
  logic                 hit;
  logic                 expire;

  always_comb begin
    low_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (bus.dl_detect_vec[i]) low_idx = PROC_ID_W'(i);
    end
  end

  // Token is home when the origin both still detects and sees its own token.
  assign hit = bus.dl_detect_vec[org_idx] & bus.token_seen_vec[org_idx];

`ifdef DEADLOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] to_cnt;

  assign expire = (state == S_TRACE) && (to_cnt == TO_LAST) && !hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state != S_TRACE || hit || expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  assign bus.token_clear    = (state == S_TRACE) && (hit || expire);
  assign bus.dl_detect_glb  = glb_q;
  assign bus.origin_vec     = origin_q;
  assign bus.dl_report_vld  = vld_q;
  assign bus.dl_report_id   = org_idx;
  assign bus.dl_report_mask = mask;
  assign bus.dl_report_cnt  = rpt_cnt;
  assign bus.state_dbg      = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      org_idx   <= '0;
      deb_cnt   <= '0;
      mask      <= '0;
      origin_q  <= '0;
      glb_q     <= 1'b0;
      vld_q     <= 1'b0;
      rpt_cnt   <= '0;
      zero_seen <= 1'b0;
    end else begin
      origin_q <= '0;
      case (state)
        S_IDLE: begin
          deb_cnt   <= '0;
          zero_seen <= 1'b0;
          if (|bus.dl_detect_vec) begin
            org_idx <= low_idx;
            state   <= S_ARM;
          end
        end
        S_ARM: begin
          if (!bus.dl_detect_vec[org_idx]) begin
            deb_cnt <= '0;
            state   <= S_IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt  <= '0;
            origin_q <= PROC_NUM'(1) << org_idx;
            mask     <= PROC_NUM'(1) << org_idx;
            glb_q    <= 1'b1;
            state    <= S_LAUNCH;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        S_LAUNCH: state <= S_TRACE;
        S_TRACE: begin
          mask <= mask | bus.token_seen_vec;
          if (hit) begin
            vld_q <= 1'b1;
            state <= S_REPORT;
          end else if (expire) begin
            glb_q <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_REPORT: begin
          if (bus.dl_report_ack) begin
            vld_q     <= 1'b0;
            glb_q     <= 1'b0;
            zero_seen <= 1'b0;
            if (rpt_cnt != 8'hff) rpt_cnt <= rpt_cnt + 1'b1;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Leave only after two consecutive quiet cycles so a persistent
          // deadlock is reported once.
          if (bus.dl_detect_vec == '0) begin
            zero_seen <= 1'b1;
            if (zero_seen) state <= S_IDLE;
          end else begin
            zero_seen <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
